countdown_timer: RTL and testbench

BCD hours:minutes:seconds countdown timer for the lab digital-clock design. It is the down-counting counterpart of the up-counting time-of-day chain. It loads a preset HH:MM:SS, decrements once per `tick` enable while running, and raises a one-cycle `done` pulse on reaching 00:00:00. Outputs feed the shared 7-segment display mux and the alarm/buzzer logic.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/bcd_down_pair.sv | 41 ++++
 rtl/countdown_timer.sv | 113 +++++++++++
 tb/tb_countdown_timer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and helpers for the lab digital-clock BCD counters.
package clock_pkg;

    localparam int unsigned BCD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } cd_state_t;

    localparam logic [BCD_W-1:0] BCD_59 = 8'h59;
    localparam logic [BCD_W-1:0] BCD_23 = 8'h23;

    // True when both nibbles are decimal digits and the value does not exceed max.
    function automatic logic bcd_valid(input logic [BCD_W-1:0] val, input logic [BCD_W-1:0] max);
        return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max);
    endfunction

endpackage

// File: rtl/bcd_down_pair.sv
// Two-digit BCD down counter; wraps 00 -> MAX and flags a borrow to the next pair.
module bcd_down_pair
    import clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = BCD_59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q,
    output logic             zero,
    output logic             borrow
);

    logic [BCD_W-1:0] q_dec;

    // Units digit 0 borrows from the tens digit and becomes 9.
    always_comb begin
        if (q[3:0] == 4'd0) begin
            q_dec = {q[7:4] - 4'd1, 4'd9};
        end else begin
            q_dec = {q[7:4], q[3:0] - 4'd1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (en) begin
            q <= zero ? MAX : q_dec;
        end
    end

    assign zero   = (q == '0);
    assign borrow = en && zero;

endmodule

// File: rtl/countdown_timer.sv
// BCD HH:MM:SS countdown timer: preset load with validation, run/pause control,
// one-cycle done pulse on reaching 00:00:00 and err pulse on a rejected preset.
module countdown_timer
    import clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX_HOURS = BCD_23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [BCD_W-1:0] preset_h,
    input  logic [BCD_W-1:0] preset_m,
    input  logic [BCD_W-1:0] preset_s,
    input  logic             start,
    input  logic             pause,
    output logic [BCD_W-1:0] hh,
    output logic [BCD_W-1:0] mm,
    output logic [BCD_W-1:0] ss,
    output logic             running,
    output logic             done,
    output logic             err
);

    cd_state_t state;

    logic preset_ok;
    logic load_ok;
    logic load_bad;
    logic cnt_zero;
    logic last_sec;
    logic dec;
    logic zero_s, zero_m, zero_h;
    logic borrow_s, borrow_m, unused_borrow_h;

    assign preset_ok = bcd_valid(preset_h, MAX_HOURS) &&
                       bcd_valid(preset_m, BCD_59) &&
                       bcd_valid(preset_s, BCD_59);

    // Load is ignored while running, so it neither loads nor blocks pause/tick there.
    assign load_ok  = load && (state != ST_RUN) && preset_ok;
    assign load_bad = load && (state != ST_RUN) && !preset_ok;

    assign cnt_zero = zero_h && zero_m && zero_s;
    assign last_sec = zero_h && zero_m && (ss == 8'h01);
    assign dec      = (state == ST_RUN) && tick && !pause && !cnt_zero;

    bcd_down_pair #(.MAX(BCD_59)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .en     (dec),
        .ld     (load_ok),
        .d      (preset_s),
        .q      (ss),
        .zero   (zero_s),
        .borrow (borrow_s)
    );

    bcd_down_pair #(.MAX(BCD_59)) u_min (
        .clk    (clk),
        .rst    (rst),
        .en     (borrow_s),
        .ld     (load_ok),
        .d      (preset_m),
        .q      (mm),
        .zero   (zero_m),
        .borrow (borrow_m)
    );

    // Hours never borrow: decrementing stops at 00:00:00.
    bcd_down_pair #(.MAX(MAX_HOURS)) u_hr (
        .clk    (clk),
        .rst    (rst),
        .en     (borrow_m),
        .ld     (load_ok),
        .d      (preset_h),
        .q      (hh),
        .zero   (zero_h),
        .borrow (unused_borrow_h)
    );

    // Control FSM with registered done/err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= dec && last_sec;
            err  <= load_bad;
            if (load_ok) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:    if (!load && start && !cnt_zero) state <= ST_RUN;
                    ST_RUN: begin
                        if (pause) begin
                            state <= ST_PAUSED;
                        end else if (dec && last_sec) begin
                            state <= ST_EXPIRED;
                        end
                    end
                    ST_PAUSED:  if (!load && start) state <= ST_RUN;
                    ST_EXPIRED: state <= ST_EXPIRED;
                    default:    state <= ST_IDLE;
                endcase
            end
        end
    end

    assign running = (state == ST_RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus randomized bench for countdown_timer against a seconds-based reference model.
module tb_countdown_timer;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSED  = 2;
    localparam int M_EXPIRED = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, load, start, pause;
    logic [7:0] preset_h, preset_m, preset_s;
    logic [7:0] hh, mm, ss;
    logic       running, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: total remaining seconds plus a coarse mode.
    int   m_sec;
    int   m_st;
    logic exp_done;
    logic exp_err;

    countdown_timer dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .preset_h (preset_h),
        .preset_m (preset_m),
        .preset_s (preset_s),
        .start    (start),
        .pause    (pause),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss),
        .running  (running),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int n);
        return 8'(((n / 10) << 4) + (n % 10));
    endfunction

    function automatic bit digits_ok(input logic [7:0] b);
        return (int'(b[7:4]) < 10) && (int'(b[3:0]) < 10);
    endfunction

    function automatic bit preset_valid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return digits_ok(h) && digits_ok(m) && digits_ok(s) &&
               (bcd2int(h) <= 23) && (bcd2int(m) <= 59) && (bcd2int(s) <= 59);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".hh"}, hh, int2bcd(m_sec / 3600));
        chk({tag, ".mm"}, mm, int2bcd((m_sec / 60) % 60));
        chk({tag, ".ss"}, ss, int2bcd(m_sec % 60));
        chk({tag, ".running"}, {7'd0, running}, {7'd0, (m_st == M_RUN)});
        chk({tag, ".done"}, {7'd0, done}, {7'd0, exp_done});
        chk({tag, ".err"}, {7'd0, err}, {7'd0, exp_err});
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, compare.
    task automatic cyc(input logic t, input logic l, input logic st, input logic pa,
                       input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                       input string tag);
        tick = t; load = l; start = st; pause = pa;
        preset_h = h; preset_m = m; preset_s = s;
        @(posedge clk);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (l && m_st != M_RUN) begin
            if (preset_valid(h, m, s)) begin
                m_sec = bcd2int(h) * 3600 + bcd2int(m) * 60 + bcd2int(s);
                m_st  = M_IDLE;
            end else begin
                exp_err = 1'b1;
            end
        end else if (pa && m_st == M_RUN) begin
            m_st = M_PAUSED;
        end else if (st && ((m_st == M_IDLE && m_sec != 0) || m_st == M_PAUSED)) begin
            m_st = M_RUN;
        end else if (t && m_st == M_RUN) begin
            m_sec = m_sec - 1;
            if (m_sec == 0) begin
                m_st     = M_EXPIRED;
                exp_done = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input string tag);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, h, m, s, tag);
    endtask

    task automatic do_start(input string tag);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, tag);
    endtask

    task automatic do_pause(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, tag);
    endtask

    task automatic do_tick(input string tag);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, tag);
    endtask

    task automatic do_idle(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r_t, r_l, r_st, r_pa;
        logic [7:0] r_h, r_m, r_s;

        rst = 1'b1;
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        preset_h = 8'h00; preset_m = 8'h00; preset_s = 8'h00;
        m_sec = 0; m_st = M_IDLE; exp_done = 1'b0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Full countdown from 00:01:05 with irregular tick spacing.
        do_load(8'h00, 8'h01, 8'h05, "t1_load");
        do_start("t1_start");
        for (int i = 0; i < 65; i++) begin
            do_tick("t1_tick");
            if ($urandom_range(0, 1) == 1) do_idle("t1_gap");
        end
        chk("t1_expired_ss", ss, 8'h00);
        for (int i = 0; i < 3; i++) do_tick("t1_hold");
        do_start("t1_start_ignored");

        // Double borrow 01:00:00 -> 00:59:59.
        do_load(8'h01, 8'h00, 8'h00, "t2_load");
        do_start("t2_start");
        do_tick("t2_tick");
        chk("t2_hh", hh, 8'h00);
        chk("t2_mm", mm, 8'h59);
        chk("t2_ss", ss, 8'h59);
        chk("t2_running", {7'd0, running}, 8'h01);

        // Rejected presets leave count and state alone.
        do_pause("t3_pause");
        do_load(8'h00, 8'h00, 8'h5A, "t3_bad_ss");
        chk("t3_err", {7'd0, err}, 8'h01);
        do_idle("t3_err_clear");
        do_load(8'h24, 8'h00, 8'h00, "t3_bad_hh");
        do_load(8'h00, 8'h60, 8'h00, "t3_bad_mm");
        do_load(8'h00, 8'h00, 8'h59, "t3_ok_59");

        // Pause beats tick; ticks ignored until start.
        do_load(8'h00, 8'h00, 8'h30, "t4_load");
        do_start("t4_start");
        do_tick("t4_tick");
        do_tick("t4_tick");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, "t4_pause_tick");
        chk("t4_ss_hold", ss, 8'h28);
        for (int i = 0; i < 3; i++) do_tick("t4_paused_tick");
        do_start("t4_resume");
        do_tick("t4_tick_resumed");

        // Start on zero count is ignored; load with start only loads.
        do_pause("t5_pause");
        do_load(8'h00, 8'h00, 8'h00, "t5_load_zero");
        do_start("t5_start_zero");
        do_tick("t5_tick_zero");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h02, 8'h00, "t5_load_start");
        chk("t5_running", {7'd0, running}, 8'h00);
        do_start("t5_start");
        do_tick("t5_tick");

        // Asynchronous reset mid-count at 00:30:17.
        do_pause("t6_pause");
        do_load(8'h00, 8'h30, 8'h18, "t6_load");
        do_start("t6_start");
        do_tick("t6_tick");
        chk("t6_ss_pre", ss, 8'h17);
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        @(negedge clk);
        #2;
        rst  = 1'b1;
        tick = 1'b1;
        #1;
        m_sec = 0; m_st = M_IDLE; exp_done = 1'b0; exp_err = 1'b0;
        check_all("t6_rst_async");
        @(posedge clk);
        #1;
        check_all("t6_rst_hold");
        @(negedge clk);
        rst  = 1'b0;
        tick = 1'b0;
        do_tick("t6_after_rst");

        // Randomized traffic; load only issued outside RUN.
        for (int i = 0; i < 1500; i++) begin
            r_t  = ($urandom_range(0, 2) == 0);
            r_st = ($urandom_range(0, 5) == 0);
            r_pa = ($urandom_range(0, 11) == 0);
            r_l  = (m_st != M_RUN) && ($urandom_range(0, 5) == 0);
            r_h  = ($urandom_range(0, 15) == 0) ? 8'($urandom) :
                   (($urandom_range(0, 7) == 0) ? int2bcd($urandom_range(0, 23)) : 8'h00);
            r_m  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 1));
            r_s  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 59));
            if (r_h != 8'h00 && m_st != M_RUN && r_l) r_m = 8'h00;
            cyc(r_t, r_l, r_st, r_pa, r_h, r_m, r_s, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
